// File: rtl/pulse_period_checker.sv
// Interval/phase checker for a periodic one-cycle pulse stream with lock tracking.
// Optional +/-1 cycle jitter tolerance: define PULSE_CHK_JITTER_EN.
module pulse_period_checker #(
    parameter int PERIOD     = 5,
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_pulse,
    output logic             locked,
    output logic [1:0]       state,
    output logic             good_strobe,
    output logic             err_strobe,
    output logic             miss_strobe,
    output logic [CNT_W-1:0] measured,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam int BC_W = $clog2(LOSS_COUNT + 1);

`ifdef PULSE_CHK_JITTER_EN
    localparam int LIMIT_I = PERIOD + 1;
    localparam int LO_I    = PERIOD - 1;
    localparam int HI_I    = PERIOD + 1;
`else
    localparam int LIMIT_I = PERIOD;
    localparam int LO_I    = PERIOD;
    localparam int HI_I    = PERIOD;
`endif

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(LIMIT_I);
    localparam logic [CNT_W-1:0] GOOD_LO  = CNT_W'(LO_I);
    localparam logic [CNT_W-1:0] GOOD_HI  = CNT_W'(HI_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [GC_W-1:0]  LOCK_TGT = GC_W'(LOCK_COUNT);
    localparam logic [BC_W-1:0]  LOSS_TGT = BC_W'(LOSS_COUNT);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_ivl, w_ivl;
    logic [CNT_W-1:0] r_ph, w_ph;
    logic [GC_W-1:0]  r_good_cnt, w_good_cnt;
    logic [BC_W-1:0]  r_bad_cnt, w_bad_cnt;
    logic [CNT_W-1:0] r_measured, w_measured;
    logic [ERR_W-1:0] r_err_count, w_err_count;
    logic             r_good_stb, w_good_stb;
    logic             r_err_stb, w_err_stb;
    logic             r_miss_stb, w_miss_stb;
    logic             r_locked;

    logic             w_good;
    logic             w_early;
    logic             w_miss;
    logic [GC_W-1:0]  w_gc_inc;
    logic [BC_W-1:0]  w_bc_inc;
    logic [ERR_W-1:0] w_err_inc;

    assign w_good    = (r_ivl >= GOOD_LO) && (r_ivl <= GOOD_HI);
    assign w_early   = (r_ivl < GOOD_LO);
    assign w_miss    = !in_pulse && (r_ph == LIMIT);
    assign w_gc_inc  = r_good_cnt + 1'b1;
    assign w_bc_inc  = r_bad_cnt + 1'b1;
    assign w_err_inc = (r_err_count == ERR_MAX) ? r_err_count
                                                : r_err_count + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_good_cnt  = r_good_cnt;
        w_bad_cnt   = r_bad_cnt;
        w_measured  = r_measured;
        w_err_count = r_err_count;
        w_good_stb  = 1'b0;
        w_err_stb   = 1'b0;
        w_miss_stb  = 1'b0;

        if (in_pulse) begin
            w_ivl = {{(CNT_W-1){1'b0}}, 1'b1};
            w_ph  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_ivl = (r_ivl == CNT_MAX) ? r_ivl : r_ivl + 1'b1;
            w_ph  = (r_ph == LIMIT) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                    : r_ph + 1'b1;
        end

        // The first pulse out of IDLE has no meaningful interval.
        if (in_pulse && r_state != S_IDLE) begin
            w_measured = r_ivl;
        end

        unique case (r_state)
            S_IDLE: begin
                if (in_pulse) begin
                    w_state    = S_ACQ;
                    w_good_cnt = '0;
                end
            end
            S_ACQ: begin
                if (in_pulse && w_good) begin
                    w_good_stb = 1'b1;
                    w_good_cnt = w_gc_inc;
                    if (w_gc_inc == LOCK_TGT) begin
                        w_state   = S_LOCKED;
                        w_bad_cnt = '0;
                    end
                end else if (in_pulse || w_miss) begin
                    w_good_cnt = '0;
                    w_miss_stb = w_miss;
                end
            end
            S_LOCKED: begin
                if (in_pulse) begin
                    if (w_good) begin
                        w_good_stb = 1'b1;
                        w_bad_cnt  = '0;
                    end else if (w_early) begin
                        w_err_stb   = 1'b1;
                        w_err_count = w_err_inc;
                        w_bad_cnt   = w_bc_inc;
                    end
                end else if (w_miss) begin
                    w_miss_stb  = 1'b1;
                    w_err_stb   = 1'b1;
                    w_err_count = w_err_inc;
                    w_bad_cnt   = w_bc_inc;
                end
                if (w_bad_cnt == LOSS_TGT) begin
                    w_state    = S_ACQ;
                    w_good_cnt = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ivl       <= '0;
            r_ph        <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_measured  <= '0;
            r_err_count <= '0;
            r_good_stb  <= 1'b0;
            r_err_stb   <= 1'b0;
            r_miss_stb  <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ivl       <= w_ivl;
            r_ph        <= w_ph;
            r_good_cnt  <= w_good_cnt;
            r_bad_cnt   <= w_bad_cnt;
            r_measured  <= w_measured;
            r_err_count <= w_err_count;
            r_good_stb  <= w_good_stb;
            r_err_stb   <= w_err_stb;
            r_miss_stb  <= w_miss_stb;
            r_locked    <= (w_state == S_LOCKED);
        end
    end

    assign locked      = r_locked;
    assign state       = r_state;
    assign good_strobe = r_good_stb;
    assign err_strobe  = r_err_stb;
    assign miss_strobe = r_miss_stb;
    assign measured    = r_measured;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker with default parameters.
module tb_pulse_period_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_pulse;
    logic        locked;
    logic [1:0]  state;
    logic        good_strobe;
    logic        err_strobe;
    logic        miss_strobe;
    logic [7:0]  measured;
    logic [15:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cg, ce, cm;

    always #5 clk = ~clk;

    pulse_period_checker dut (
        .clk         (clk),
        .reset       (reset),
        .in_pulse    (in_pulse),
        .locked      (locked),
        .state       (state),
        .good_strobe (good_strobe),
        .err_strobe  (err_strobe),
        .miss_strobe (miss_strobe),
        .measured    (measured),
        .err_count   (err_count)
    );

    task automatic step(input logic p);
        in_pulse = p;
        @(posedge clk);
        #1;
        cg += int'(good_strobe);
        ce += int'(err_strobe);
        cm += int'(miss_strobe);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic clr();
        cg = 0; ce = 0; cm = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0);
        step(1'b0);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %0b want 0", locked); end
        n_tests++; if (measured !== 8'd0) begin n_fail++; $display("FAIL rst_measured got %0d want 0", measured); end
        n_tests++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_errcnt got %0d want 0", err_count); end
        n_tests++; if ({good_strobe, err_strobe, miss_strobe} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes got %b want 000", {good_strobe, err_strobe, miss_strobe}); end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        clr();
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            if (k == 2) begin
                n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %0b want 0", locked); end
            end
            if (k == 3) begin
                n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked got %0b want 1", locked); end
                n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL lock_state got %0d want 2", state); end
            end
            zeros(4);
        end
        n_tests++; if (cg != 3) begin n_fail++; $display("FAIL lock_goods got %0d want 3", cg); end
        n_tests++; if (ce + cm != 0) begin n_fail++; $display("FAIL lock_errs got %0d want 0", ce + cm); end
        n_tests++; if (measured !== 8'd5) begin n_fail++; $display("FAIL lock_measured got %0d want 5", measured); end
        n_tests++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL lock_errcnt got %0d want 0", err_count); end
    endtask

    task automatic test_missing();
        step(1'b0);
        n_tests++; if ({miss_strobe, err_strobe} !== 2'b11) begin n_fail++; $display("FAIL miss_strobes got %b want 11", {miss_strobe, err_strobe}); end
        n_tests++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL miss_errcnt got %0d want 1", err_count); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL miss_locked got %0b want 1", locked); end
        clr();
        zeros(4);
        step(1'b1);
        n_tests++; if (cg + ce + cm != 0) begin n_fail++; $display("FAIL late_strobes got %0d want 0", cg + ce + cm); end
        n_tests++; if (measured !== 8'd10) begin n_fail++; $display("FAIL late_measured got %0d want 10", measured); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL late_locked got %0b want 1", locked); end
        zeros(4);
        step(1'b1);
        n_tests++; if (good_strobe !== 1'b1) begin n_fail++; $display("FAIL recov_good got %0b want 1", good_strobe); end
        n_tests++; if (measured !== 8'd5) begin n_fail++; $display("FAIL recov_measured got %0d want 5", measured); end
        zeros(4);
    endtask

    task automatic test_hold_low();
        step(1'b0);
        n_tests++; if ({miss_strobe, err_strobe} !== 2'b11) begin n_fail++; $display("FAIL hold1_strobes got %b want 11", {miss_strobe, err_strobe}); end
        n_tests++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL hold1_errcnt got %0d want 2", err_count); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hold1_locked got %0b want 1", locked); end
        zeros(4);
        step(1'b0);
        n_tests++; if ({miss_strobe, err_strobe} !== 2'b11) begin n_fail++; $display("FAIL hold2_strobes got %b want 11", {miss_strobe, err_strobe}); end
        n_tests++; if (err_count !== 16'd3) begin n_fail++; $display("FAIL hold2_errcnt got %0d want 3", err_count); end
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL hold2_state got %0d want 1", state); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL hold2_locked got %0b want 0", locked); end
        clr();
        zeros(10);
        n_tests++; if (cm != 2) begin n_fail++; $display("FAIL acq_misses got %0d want 2", cm); end
        n_tests++; if (ce != 0) begin n_fail++; $display("FAIL acq_errs got %0d want 0", ce); end
        n_tests++; if (err_count !== 16'd3) begin n_fail++; $display("FAIL acq_errcnt got %0d want 3", err_count); end
    endtask

    task automatic test_early();
        step(1'b1);
        for (int k = 0; k < 3; k++) begin
            zeros(4);
            step(1'b1);
        end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock got %0b want 1", locked); end
        zeros(2);
        step(1'b1);
        n_tests++; if (err_strobe !== 1'b1) begin n_fail++; $display("FAIL early_err got %0b want 1", err_strobe); end
        n_tests++; if (measured !== 8'd3) begin n_fail++; $display("FAIL early_measured got %0d want 3", measured); end
        n_tests++; if (err_count !== 16'd4) begin n_fail++; $display("FAIL early_errcnt got %0d want 4", err_count); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL early_locked got %0b want 1", locked); end
        zeros(4);
        step(1'b1);
        n_tests++; if (good_strobe !== 1'b1) begin n_fail++; $display("FAIL early_resume got %0b want 1", good_strobe); end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL early_resume_lk got %0b want 1", locked); end
        zeros(4);
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step(1'b1);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL mrst_state got %0d want 0", state); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mrst_locked got %0b want 0", locked); end
        n_tests++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL mrst_errcnt got %0d want 0", err_count); end
        n_tests++; if (measured !== 8'd0) begin n_fail++; $display("FAIL mrst_measured got %0d want 0", measured); end
        n_tests++; if ({good_strobe, err_strobe, miss_strobe} !== 3'b000) begin n_fail++; $display("FAIL mrst_strobes got %b want 000", {good_strobe, err_strobe, miss_strobe}); end
        reset = 1'b0;
    endtask

    task automatic test_jitter();
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        clr();
        step(1'b1);
        n_tests++; if (measured !== 8'd0) begin n_fail++; $display("FAIL first_measured got %0d want 0", measured); end
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL first_state got %0d want 1", state); end
        for (int k = 0; k < 8; k++) begin
            zeros((k % 2 == 1) ? 5 : 3);
            step(1'b1);
        end
        n_tests++; if (measured !== 8'd6) begin n_fail++; $display("FAIL alt_measured got %0d want 6", measured); end
        n_tests++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL alt_errcnt got %0d want 0", err_count); end
`ifdef PULSE_CHK_JITTER_EN
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL alt_locked got %0b want 1", locked); end
        n_tests++; if (cg != 8) begin n_fail++; $display("FAIL alt_goods got %0d want 8", cg); end
        n_tests++; if (cm != 0) begin n_fail++; $display("FAIL alt_misses got %0d want 0", cm); end
`else
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL alt_state got %0d want 1", state); end
        n_tests++; if (cg != 0) begin n_fail++; $display("FAIL alt_goods got %0d want 0", cg); end
        n_tests++; if (cm != 4) begin n_fail++; $display("FAIL alt_misses got %0d want 4", cm); end
`endif
    endtask

    initial begin
        reset    = 1'b1;
        in_pulse = 1'b0;
        clr();
        test_reset();
        test_lock();
        test_missing();
        test_hold_low();
        test_early();
        test_reset_mid();
        test_jitter();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
